counter20_driver: RTL and testbench

//  Initiator for the counter20 start/ud/state interface: walks a counter20 instance to a requested target.
//  On go, it compares the counter's state with the target and issues start pulses with the correct ud.

---
 rtl/counter20_pkg.sv | 23 ++
 rtl/counter20_driver_if.sv | 30 +++
 rtl/counter20.sv | 35 +++
 rtl/counter20_driver_hold_timer.sv | 28 ++
 rtl/counter20_driver.sv | 169 ++++++++++++++++
 tb/tb_counter20_driver.sv | 195 +++++++++++++++++++
 6 files changed

// File: rtl/counter20_pkg.sv
// Shared definitions for counter20 and its driver: value range, ud encoding, driver FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package counter20_pkg;

    // Highest legal counter value; the counter range is 0..MAX_VAL.
    localparam int MAX_VAL = 19;

    // ud encoding on the counter20 interface.
    localparam logic UD_UP   = 1'b0;
    localparam logic UD_DOWN = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_PRESS,
        S_GAP,
        S_WAIT,
        S_DONE,
        S_ERR
    } drv_state_t;

endpackage

// File: rtl/counter20_driver_if.sv
// Request/response and counter20 start/ud/state signals of the driver, bundled.
// Latency: n/a (wiring only).
// Backpressure: go is ignored while busy; there is no queueing.
// Ports: go/target (request), state (from counter20), start/ud (to counter20),
//        busy/done/err/presses (status back to the requester).
interface counter20_driver_if #(
    parameter int WIDTH = 5
);
    logic             go;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] state;
    logic             start;
    logic             ud;
    logic             busy;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] presses;

    // master: the driver itself.
    modport master (
        input  go, target, state,
        output start, ud, busy, done, err, presses
    );

    // slave: requester plus counter20 side, seen from outside the driver.
    modport slave (
        output go, target, state,
        input  start, ud, busy, done, err, presses
    );
endinterface

// File: rtl/counter20.sv
// Up/down counter over 0..MAX_VAL stepped once per rising edge of start.
// Latency: state changes on the first edge that samples start high.
// Backpressure: none; a start held high steps only once.
// Ports: clk, reset (sync, active-high), start, ud, state.
module counter20
    import counter20_pkg::*;
#(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ud,
    output logic [WIDTH-1:0] state
);
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_VAL);

    logic start_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= '0;
            start_q <= 1'b0;
        end else begin
            start_q <= start;
            if (start && !start_q) begin
                if (ud == UD_DOWN) begin
                    state <= (state == '0) ? TOP : state - WIDTH'(1);
                end else begin
                    state <= (state == TOP) ? '0 : state + WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: rtl/counter20_driver_hold_timer.sv
// Loadable down-counter shared by the PRESS/GAP/WAIT phases of the driver.
// Latency: load takes effect on the next edge; expired is high while the count is zero.
// Backpressure: none; load overrides counting.
// Ports: clk, reset (sync, active-high), load, load_val, expired.
module hold_timer #(
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          expired
);
    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - TW'(1);
        end
    end

    // Loading N-1 gives a phase of exactly N cycles ending on the expired cycle.
    assign expired = (count == '0);
endmodule

// File: rtl/counter20_driver.sv
// Walks a counter20 to a requested target with checked start pulses, one step at a time.
// Latency: 1 (CHECK) + PRESS_CYC + GAP_CYC + k cycles per step, plus accept and DONE/ERR cycles.
// Backpressure: go is sampled only in IDLE; requests while busy or during DONE/ERR are dropped.
// Ports: mclk, reset (sync, active-high), bus (master): go/target/state in, start/ud/busy/done/err/presses out.
module counter20_driver
    import counter20_pkg::*;
#(
    parameter int WIDTH      = 5,
    parameter int MAX_VAL    = counter20_pkg::MAX_VAL,
    parameter int PRESS_CYC  = 1,
    parameter int GAP_CYC    = 1,
    parameter int SETTLE_CYC = 4
) (
    input  logic             mclk,
    input  logic             reset,
    counter20_driver_if.master bus
);
    localparam int TMAX_A = (PRESS_CYC > GAP_CYC) ? PRESS_CYC : GAP_CYC;
    localparam int TMAX   = (TMAX_A > SETTLE_CYC) ? TMAX_A : SETTLE_CYC;
    localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    drv_state_t       fsm;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] exp_state;   // value the counter must reach after this pulse
    logic [WIDTH-1:0] base_state;  // value before the pulse; anything else but exp is an error
    logic [WIDTH-1:0] presses;
    logic             start;
    logic             ud;
    logic             busy;
    logic             done;
    logic             err;

    logic             tgt_ok;
    logic             step_go;
    logic             tmr_load;
    logic [TW-1:0]    tmr_val;
    logic             tmr_expired;

    assign tgt_ok  = (tgt <= MAX_W);
    assign step_go = (fsm == S_CHECK) && tgt_ok && (bus.state != tgt);

    // The timer is reloaded on the same edge the FSM enters PRESS, GAP or WAIT.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (fsm)
            S_CHECK: begin
                if (step_go) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(PRESS_CYC - 1);
                end
            end
            S_PRESS: begin
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(GAP_CYC - 1);
                end
            end
            S_GAP: begin
                if (tmr_expired) begin
                    tmr_load = 1'b1;
                    tmr_val  = TW'(SETTLE_CYC - 1);
                end
            end
            default: begin
            end
        endcase
    end

    hold_timer #(
        .TW(TW)
    ) u_timer (
        .clk      (mclk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    always_ff @(posedge mclk) begin
        if (reset) begin
            fsm        <= S_IDLE;
            tgt        <= '0;
            exp_state  <= '0;
            base_state <= '0;
            presses    <= '0;
            start      <= 1'b0;
            ud         <= UD_UP;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (fsm)
                S_IDLE: begin
                    if (bus.go) begin
                        tgt     <= bus.target;
                        presses <= '0;
                        busy    <= 1'b1;
                        fsm     <= S_CHECK;
                        // Direction is settled on entry to CHECK so ud is quiet for a
                        // full cycle before start can rise.
                        if (bus.target != bus.state) begin
                            ud <= (bus.target < bus.state) ? UD_DOWN : UD_UP;
                        end
                    end
                end
                S_CHECK: begin
                    if (!tgt_ok) begin
                        err <= 1'b1;
                        fsm <= S_ERR;
                    end else if (bus.state == tgt) begin
                        done <= 1'b1;
                        fsm  <= S_DONE;
                    end else begin
                        exp_state  <= (ud == UD_DOWN) ? bus.state - WIDTH'(1)
                                                      : bus.state + WIDTH'(1);
                        base_state <= bus.state;
                        start      <= 1'b1;
                        if (presses != '1) begin
                            presses <= presses + WIDTH'(1);
                        end
                        fsm <= S_PRESS;
                    end
                end
                S_PRESS: begin
                    if (tmr_expired) begin
                        start <= 1'b0;
                        fsm   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (tmr_expired) begin
                        fsm <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Reaching exp wins even on the timer's last cycle.
                    if (bus.state == exp_state) begin
                        fsm <= S_CHECK;
                        if (tgt != bus.state) begin
                            ud <= (tgt < bus.state) ? UD_DOWN : UD_UP;
                        end
                    end else if ((bus.state != base_state) || tmr_expired) begin
                        err <= 1'b1;
                        fsm <= S_ERR;
                    end
                end
                S_DONE, S_ERR: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    busy <= 1'b0;
                    fsm  <= S_IDLE;
                end
                default: begin
                    fsm <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.start   = start;
    assign bus.ud      = ud;
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.err     = err;
    assign bus.presses = presses;
endmodule

// File: tb/tb_counter20_driver.sv
// Bench for counter20_driver driving a counter20, with a stuck and a jumping counter stand-in.
// Latency: n/a.
// Backpressure: n/a.
module tb_counter20_driver;
    import counter20_pkg::*;

    typedef struct {
        logic       is_err;
        logic [4:0] presses;
        logic [4:0] state;
    } exp_t;

    logic       mclk = 1'b0;
    logic       reset = 1'b1;
    logic       use_model = 1'b0;
    logic       model_jump = 1'b0;
    logic       jumped = 1'b0;
    logic [4:0] model_state;
    logic [4:0] cnt_state;
    logic       cnt_start;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    counter20_driver_if #(.WIDTH(5)) bus();

    counter20_driver #(
        .WIDTH(5), .MAX_VAL(19), .PRESS_CYC(1), .GAP_CYC(1), .SETTLE_CYC(4)
    ) dut (
        .mclk  (mclk),
        .reset (reset),
        .bus   (bus)
    );

    // The real counter is isolated while a stand-in model drives state.
    assign cnt_start = bus.start & ~use_model;

    counter20 #(.WIDTH(5)) u_cnt (
        .clk   (mclk),
        .reset (reset),
        .start (cnt_start),
        .ud    (bus.ud),
        .state (cnt_state)
    );

    // Stand-in: stuck at 3, or jumps from 3 straight to 5 on a start pulse.
    always @(posedge mclk) begin
        if (!model_jump) jumped <= 1'b0;
        else if (bus.start) jumped <= 1'b1;
    end
    assign model_state = jumped ? 5'd5 : 5'd3;
    assign bus.state   = use_model ? model_state : cnt_state;

    always #10 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One request: push the expectation, pulse go, watch pulses until done/err, then compare.
    task automatic run_req(input string name, input int tgt, input bit e_err, input int e_presses,
                           input int e_state, input bit e_ud, input int e_lat, input int extra_go);
        exp_t e;
        int   cyc = 0;
        int   pulses = 0;
        int   ud_wrong = 0;
        int   ud_moved = 0;
        bit   seen = 0;
        logic prev_start;
        logic prev_ud;
        e.is_err  = e_err;
        e.presses = 5'(e_presses);
        e.state   = 5'(e_state);
        sb.push_back(e);
        bus.target = 5'(tgt);
        bus.go     = 1'b1;
        @(posedge mclk); #1;
        bus.go = 1'b0;
        cyc = 1;
        prev_start = 1'b0;
        prev_ud    = bus.ud;
        while (!seen && cyc < 300) begin
            if (bus.start) begin
                if (!prev_start) pulses++;
                if (bus.ud !== e_ud) ud_wrong++;
                if (bus.ud !== prev_ud) ud_moved++;
            end
            prev_start = bus.start;
            prev_ud    = bus.ud;
            if (bus.done || bus.err) begin
                seen = 1;
            end else begin
                if (cyc == extra_go) begin
                    bus.go     = 1'b1;
                    bus.target = 5'd1;
                end else begin
                    bus.go = 1'b0;
                end
                @(posedge mclk); #1;
                cyc++;
            end
        end
        bus.go = 1'b0;
        chk({name, "_finished"}, 32'(seen), 32'd1);
        if (sb.size() > 0) e = sb.pop_front();
        if (seen) begin
            chk({name, "_err"},      32'(bus.err),     32'(e.is_err));
            chk({name, "_done"},     32'(bus.done),    32'(!e.is_err));
            chk({name, "_presses"},  32'(bus.presses), 32'(e.presses));
            chk({name, "_state"},    32'(bus.state),   32'(e.state));
            chk({name, "_pulses"},   32'(pulses),      32'(e.presses));
            chk({name, "_ud_dir"},   32'(ud_wrong),    32'd0);
            chk({name, "_ud_moved"}, 32'(ud_moved),    32'd0);
            chk({name, "_busy_end"}, 32'(bus.busy),    32'd1);
            if (e_lat > 0) chk({name, "_latency"}, 32'(cyc), 32'(e_lat));
            else chk({name, "_lat_bound"}, 32'(cyc <= e_presses * 8 + 2), 32'd1);
        end
        // A go during the DONE/ERR cycle must be dropped.
        bus.go = 1'b1;
        @(posedge mclk); #1;
        bus.go = 1'b0;
        chk({name, "_busy_drop"}, 32'(bus.busy), 32'd0);
        chk({name, "_pulse_end"}, 32'(bus.done | bus.err), 32'd0);
        @(posedge mclk); #1;
        chk({name, "_go_ignored"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int n;
        bus.go     = 1'b0;
        bus.target = 5'd0;

        repeat (3) @(posedge mclk);
        #1;
        chk("rst_start",   32'(bus.start),   32'd0);
        chk("rst_ud",      32'(bus.ud),      32'd0);
        chk("rst_busy",    32'(bus.busy),    32'd0);
        chk("rst_done",    32'(bus.done),    32'd0);
        chk("rst_err",     32'(bus.err),     32'd0);
        chk("rst_presses", 32'(bus.presses), 32'd0);
        chk("rst_state",   32'(bus.state),   32'd0);
        reset = 1'b0;
        @(posedge mclk); #1;

        run_req("up5",     5,  0, 5,  5,  UD_UP,   0, 0);
        run_req("up19",    19, 0, 14, 19, UD_UP,   0, 0);
        run_req("down0",   0,  0, 19, 0,  UD_DOWN, 0, 0);
        run_req("up7",     7,  0, 7,  7,  UD_UP,   0, 0);
        run_req("same7",   7,  0, 0,  7,  UD_UP,   2, 0);
        run_req("illegal", 25, 1, 0,  7,  UD_UP,   2, 0);

        use_model = 1'b1;
        model_jump = 1'b0;
        @(posedge mclk); #1;
        run_req("stuck",   4,  1, 1,  3,  UD_UP,   8, 0);
        model_jump = 1'b1;
        @(posedge mclk); #1;
        run_req("jump",    4,  1, 1,  5,  UD_UP,   5, 0);
        model_jump = 1'b0;
        use_model  = 1'b0;
        @(posedge mclk); #1;

        run_req("back0",   0,  0, 7,  0,  UD_DOWN, 0, 0);

        // Reset in the middle of a pulse of a 0->10 request.
        bus.target = 5'd10;
        bus.go     = 1'b1;
        @(posedge mclk); #1;
        bus.go = 1'b0;
        n = 0;
        while (!bus.start && n < 20) begin
            @(posedge mclk); #1;
            n++;
        end
        chk("midrst_press_seen", 32'(bus.start), 32'd1);
        reset = 1'b1;
        @(posedge mclk); #1;
        chk("midrst_start",   32'(bus.start),   32'd0);
        chk("midrst_busy",    32'(bus.busy),    32'd0);
        chk("midrst_presses", 32'(bus.presses), 32'd0);
        reset = 1'b0;
        @(posedge mclk); #1;

        run_req("after_rst", 3, 0, 3, 3, UD_UP, 0, 0);
        run_req("go_busy",   6, 0, 3, 6, UD_UP, 0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
